// File: rtl/vga_scanout_pkg.sv
// Shared constants for the VGA scan-out path: 640x480@60 timing,
// the 40x30 cell grid and the 3-bit colour codes used by the CPU.
package vga_scanout_pkg;

    localparam int VGA_PIX_DIV    = 2;

    localparam int VGA_H_VISIBLE  = 640;
    localparam int VGA_H_FRONT    = 16;
    localparam int VGA_H_SYNC     = 96;
    localparam int VGA_H_BACK     = 48;
    localparam int VGA_H_TOTAL    = 800;

    localparam int VGA_V_VISIBLE  = 480;
    localparam int VGA_V_FRONT    = 10;
    localparam int VGA_V_SYNC     = 2;
    localparam int VGA_V_BACK     = 33;
    localparam int VGA_V_TOTAL    = 525;

    localparam int VGA_CELL_SHIFT = 4;
    localparam int GRID_COLS      = 40;
    localparam int GRID_ROWS      = 30;
    localparam int VMEM_ADDR_W    = 11;
    localparam int VMEM_COLOR_W   = 3;

    // bit2=R, bit1=G, bit0=B
    typedef enum logic [2:0] {
        COLOR_BLACK   = 3'b000,
        COLOR_BLUE    = 3'b001,
        COLOR_GREEN   = 3'b010,
        COLOR_CYAN    = 3'b011,
        COLOR_RED     = 3'b100,
        COLOR_MAGENTA = 3'b101,
        COLOR_YELLOW  = 3'b110,
        COLOR_WHITE   = 3'b111
    } color_t;

    // Position flags carried from the address stage to the pin stage
    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
    } s1_flags_t;

endpackage

// File: rtl/vga_scanout_timing_gen.sv
// vga_timing_gen: pixel-tick divider, h/v counters, position flags
// and a registered frame-start pulse.
// Ports: clock, reset (sync, active-high) -> tick, hcnt, vcnt,
//        visible, hsync_on, vsync_on (active-high), frame_start.
module vga_timing_gen #(
    parameter int PIX_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int HW        = 10,
    parameter int VW        = 10
) (
    input  logic          clock,
    input  logic          reset,
    output logic          tick,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          visible,
    output logic          hsync_on,
    output logic          vsync_on,
    output logic          frame_start
);

    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DW = (PIX_DIV > 2) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DW-1:0] div;
    logic          h_wrap;
    logic          v_wrap;

    assign tick   = (div == DIV_LAST);
    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            frame_start <= 1'b0;
        end else begin
            div         <= tick ? '0 : div + DW'(1);
            // high for the clock after counters return to (0,0)
            frame_start <= tick && h_wrap && v_wrap;
            if (tick) begin
                if (h_wrap) begin
                    hcnt <= '0;
                    vcnt <= v_wrap ? '0 : vcnt + VW'(1);
                end else begin
                    hcnt <= hcnt + HW'(1);
                end
            end
        end
    end

    assign visible  = (hcnt < H_VIS) && (vcnt < V_VIS);
    assign hsync_on = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vsync_on = (vcnt >= VS_BEG) && (vcnt < VS_END);

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: reads the 40x30 cell video memory and drives a
// 640x480@60 monitor through a 2-tick address/pin pipeline.
// Ports: Clock, Reset (sync, active-high), oVMemAddress/iVMemColor
//        (1-clock read latency), oVGA_R/G/B, oHSync, oVSync
//        (active low), oFrameStart (one-clock pulse per frame).
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int PIX_DIV    = VGA_PIX_DIV,
    parameter int H_VISIBLE  = VGA_H_VISIBLE,
    parameter int H_FRONT    = VGA_H_FRONT,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BACK     = VGA_H_BACK,
    parameter int V_VISIBLE  = VGA_V_VISIBLE,
    parameter int V_FRONT    = VGA_V_FRONT,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BACK     = VGA_V_BACK,
    parameter int CELL_SHIFT = VGA_CELL_SHIFT,
    parameter int COLS       = GRID_COLS,
    parameter int ADDR_W     = VMEM_ADDR_W,
    parameter int COLOR_W    = VMEM_COLOR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [ADDR_W-1:0] oVMemAddress,
    input  logic [COLOR_W-1:0] iVMemColor,
    output logic              oVGA_R,
    output logic              oVGA_G,
    output logic              oVGA_B,
    output logic              oHSync,
    output logic              oVSync,
    output logic              oFrameStart
);

    localparam int HW = $clog2(H_VISIBLE + H_FRONT + H_SYNC + H_BACK + 1);
    localparam int VW = $clog2(V_VISIBLE + V_FRONT + V_SYNC + V_BACK + 1);

    logic          tick;
    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic          visible;
    logic          hsync_on;
    logic          vsync_on;

    vga_timing_gen #(
        .PIX_DIV   (PIX_DIV),
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK),
        .HW        (HW),
        .VW        (VW)
    ) u_timing (
        .clock       (Clock),
        .reset       (Reset),
        .tick        (tick),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .visible     (visible),
        .hsync_on    (hsync_on),
        .vsync_on    (vsync_on),
        .frame_start (oFrameStart)
    );

    logic [ADDR_W-1:0]  row_a;
    logic [ADDR_W-1:0]  col_a;
    logic [ADDR_W-1:0]  addr_n;
    s1_flags_t          s1;
    logic [COLOR_W-1:0] rgb;

    assign row_a  = ADDR_W'(vcnt >> CELL_SHIFT);
    assign col_a  = ADDR_W'(hcnt >> CELL_SHIFT);
    assign addr_n = row_a * ADDR_W'(COLS) + col_a;

    // Stage 1 issues the read; stage 2 consumes it one tick later,
    // so the syncs travel with the same 2-tick delay as the colour.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            oVMemAddress <= '0;
            s1           <= '0;
            rgb          <= '0;
            oHSync       <= 1'b1;
            oVSync       <= 1'b1;
        end else if (tick) begin
            oVMemAddress <= visible ? addr_n : '0;
            s1           <= '{vis: visible, hs: hsync_on, vs: vsync_on};
            rgb          <= s1.vis ? iVMemColor : '0;
            oHSync       <= ~s1.hs;
            oVSync       <= ~s1.vs;
        end
    end

    assign oVGA_R = rgb[2];
    assign oVGA_G = rgb[1];
    assign oVGA_B = rgb[0];

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a full-size instance (colour = addr[2:0])
// and a shrunken instance (PIX_DIV=3) with random memory contents.
module tb_vga_scanout;

    typedef struct {
        int pd;
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        int cols;
    } cfg_t;

    cfg_t ca = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 40};
    cfg_t cb = '{3, 64, 4, 8, 4, 48, 2, 2, 3, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset = 1'b1;
    logic [10:0] addr_a, addr_b;
    logic [2:0]  col_a, col_b;
    logic        ra, ga, ba, hs_a, vs_a, fs_a;
    logic        rb, gb, bb, hs_b, vs_b, fs_b;
    logic [2:0]  mem_b [0:2047];

    vga_scanout dut_a (
        .Clock        (clk),
        .Reset        (Reset),
        .oVMemAddress (addr_a),
        .iVMemColor   (col_a),
        .oVGA_R       (ra),
        .oVGA_G       (ga),
        .oVGA_B       (ba),
        .oHSync       (hs_a),
        .oVSync       (vs_a),
        .oFrameStart  (fs_a)
    );

    vga_scanout #(
        .PIX_DIV   (3),
        .H_VISIBLE (64),
        .H_FRONT   (4),
        .H_SYNC    (8),
        .H_BACK    (4),
        .V_VISIBLE (48),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (3),
        .COLS      (4)
    ) dut_b (
        .Clock        (clk),
        .Reset        (Reset),
        .oVMemAddress (addr_b),
        .iVMemColor   (col_b),
        .oVGA_R       (rb),
        .oVGA_G       (gb),
        .oVGA_B       (bb),
        .oHSync       (hs_b),
        .oVSync       (vs_b),
        .oFrameStart  (fs_b)
    );

    // memories with one clock of read latency
    always @(posedge clk) begin
        col_a <= addr_a[2:0];
        col_b <= mem_b[addr_b];
    end

    int n      = 0;
    int cyc    = 0;
    int n_asrt = 0;
    int n_fail = 0;

    logic prev_hs_a = 1'b1;
    logic prev_vs_b = 1'b1;
    int a_fall = -1, a_low = -1, b_vlow = -1, b_fs = -1;
    bit b_first = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)",
                   tag, got, exp, cyc);
        end
    endtask

    function automatic int addr_of(input cfg_t c, input int p);
        int ht, h, v;
        ht = c.hv + c.hf + c.hs + c.hb;
        h  = p % ht;
        v  = p / ht;
        if (h < c.hv && v < c.vv)
            return (v / 16) * c.cols + (h / 16);
        return 0;
    endfunction

    // Expected pins from elapsed clocks since reset release:
    // a tick ends every pd clocks, the address shows the position of
    // the previous tick, the pins the position two ticks back.
    task automatic check(input cfg_t c, input bit is_a,
                         input logic [10:0] addr, input logic [2:0] rgb,
                         input logic hs, input logic vs, input logic fs,
                         input string nm);
        int ht, vt, f, t, p, h, v, ea, a;
        logic [2:0] ergb;
        logic ehs, evs, efs;
        ht = c.hv + c.hf + c.hs + c.hb;
        vt = c.vv + c.vf + c.vs + c.vb;
        f  = ht * vt;
        t  = n / c.pd;
        ea = (t >= 1) ? addr_of(c, (t - 1) % f) : 0;
        ergb = 3'b000;
        ehs  = 1'b1;
        evs  = 1'b1;
        if (t >= 2) begin
            p = (t - 2) % f;
            h = p % ht;
            v = p / ht;
            if (h < c.hv && v < c.vv) begin
                a    = addr_of(c, p);
                ergb = is_a ? 3'(a) : mem_b[a];
            end
            ehs = !(h >= c.hv + c.hf && h < c.hv + c.hf + c.hs);
            evs = !(v >= c.vv + c.vf && v < c.vv + c.vf + c.vs);
        end
        efs = (n >= 1) && (n % c.pd == 0) && (t % f == 0);
        chk({nm, ".addr"}, 32'(addr), ea);
        chk({nm, ".range"}, 32'(addr < 11'(c.cols * (c.vv / 16))), 1);
        chk({nm, ".rgb"}, 32'(rgb), 32'(ergb));
        chk({nm, ".hsync"}, 32'(hs), 32'(ehs));
        chk({nm, ".vsync"}, 32'(vs), 32'(evs));
        chk({nm, ".fstart"}, 32'(fs), 32'(efs));
    endtask

    task automatic step(input logic rst);
        Reset = rst;
        @(posedge clk);
        if (rst) n = 0;
        else n++;
        cyc++;
        @(negedge clk);
        check(ca, 1'b1, addr_a, {ra, ga, ba}, hs_a, vs_a, fs_a, "A");
        check(cb, 1'b0, addr_b, {rb, gb, bb}, hs_b, vs_b, fs_b, "B");
        if (Reset) begin
            a_fall  = -1;
            a_low   = -1;
            b_vlow  = -1;
            b_first = 1'b1;
        end else begin
            if (prev_hs_a && !hs_a) begin
                if (a_fall >= 0) chk("A.line_period", cyc - a_fall, 1600);
                a_fall = cyc;
                a_low  = cyc;
            end
            if (!prev_hs_a && hs_a && a_low >= 0)
                chk("A.hsync_width", cyc - a_low, 192);
            if (prev_vs_b && !vs_b) b_vlow = cyc;
            if (!prev_vs_b && vs_b && b_vlow >= 0)
                chk("B.vsync_width", cyc - b_vlow, 2 * 80 * 3);
            if (fs_b) begin
                if (b_first) chk("B.first_frame", n, 80 * 55 * 3);
                else chk("B.frame_period", cyc - b_fs, 80 * 55 * 3);
                b_fs    = cyc;
                b_first = 1'b0;
            end
        end
        prev_hs_a = hs_a;
        prev_vs_b = vs_b;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 2048; i++) mem_b[i] = 3'($urandom);
        @(negedge clk);

        // reset held 5 clocks, then two small frames
        for (int i = 0; i < 5; i++) step(1'b1);
        for (int i = 0; i < 2 * 13200 + 500; i++) step(1'b0);

        // one-clock reset at a random point
        k = $urandom_range(500, 2000);
        for (int i = 0; i < k; i++) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 300; i++) step(1'b0);

        // one-clock reset with the small instance at (h=30, v=20)
        k = 0;
        while (k < 20000 && ((n / 3) % 4400) != 20 * 80 + 30) begin
            step(1'b0);
            k++;
        end
        chk("B.seek", (n / 3) % 4400, 20 * 80 + 30);
        step(1'b1);
        for (int i = 0; i < 200; i++) step(1'b0);

        // whole screen magenta, loaded while held in reset
        step(1'b1);
        for (int i = 0; i < 2048; i++) mem_b[i] = 3'b101;
        step(1'b1);
        step(1'b1);
        for (int i = 0; i < 13200 + 300; i++) step(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end

endmodule
